spi_slave_regfile: RTL and testbench

- Stand-alone SPI slave endpoint: the responder that the SPI master core addresses over SS/SCK/MOSI/MISO.
- Oversamples the SPI pins in the system clock domain and decodes a 2-byte command/data frame.
- Writes to, or reads back from, a small internal byte register file.
- Used as the bench/peer device for master-mode bring-up, and as a reusable register-mapped slave.

---
 rtl/spi_slave_regfile.sv | 205 ++++++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regfile.sv
// SPI slave endpoint: oversamples SS/SCK/MOSI in the clk domain, decodes a
// command/data byte pair and reads or writes a small byte register file.
module spi_slave_regfile #(
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCK,
  input  logic              SS,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_oe,
  input  logic              CPOL,
  input  logic              CPHA,
  input  logic              LSBFE,
  input  logic [ADDR_W-1:0] usr_addr,
  output logic [7:0]        usr_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_err
);

  localparam int unsigned NREGS = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, CMD, DATA, HOLD} state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sck_sync_q, ss_sync_q, mosi_sync_q;
  logic                    sck_prev_q, ss_prev_q;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [7:0]              rx_q, rx_d, tx_q, tx_d;
  logic                    rnw_q, rnw_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic                    busy_q, busy_d, frame_err_q, frame_err_d;
  logic                    wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
  logic [7:0]              wr_data_q, wr_data_d;
  logic [7:0]              regs_q [NREGS];
  logic [7:0]              usr_rdata_q;

  logic sck_s, ss_s, mosi_s;
  logic sck_edge_c, lead_c, trail_c, sample_c, shift_c, ss_fall_c, ss_rise_c;
  logic reg_we_c, miso_bit_c;
  logic [7:0] rx_next_c, tx_shift_c;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Leading edge leaves the idle level CPOL; CPHA picks which edge samples.
  assign sck_edge_c = sck_s != sck_prev_q;
  assign lead_c     = sck_edge_c && (sck_s != CPOL);
  assign trail_c    = sck_edge_c && (sck_s == CPOL);
  assign sample_c   = CPHA ? trail_c : lead_c;
  assign shift_c    = CPHA ? lead_c  : trail_c;
  assign ss_fall_c  = ss_prev_q && !ss_s;
  assign ss_rise_c  = !ss_prev_q && ss_s;

  assign rx_next_c  = LSBFE ? {mosi_s, rx_q[7:1]} : {rx_q[6:0], mosi_s};
  assign miso_bit_c = LSBFE ? tx_q[0] : tx_q[7];
  assign tx_shift_c = LSBFE ? {1'b0, tx_q[7:1]} : {tx_q[6:0], 1'b0};

  // Pin synchronizers and edge-detect history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync_q  <= {SYNC_STAGES{CPOL}};
      ss_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= '0;
      sck_prev_q  <= CPOL;
      ss_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
    end
  end

  // Frame FSM: next state and registered outputs.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rnw_d       = rnw_q;
    addr_d      = addr_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    busy_d      = busy_q;
    frame_err_d = 1'b0;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    reg_we_c    = 1'b0;

    if (ss_rise_c) begin
      state_d     = IDLE;
      busy_d      = 1'b0;
      miso_oe_d   = 1'b0;
      miso_d      = 1'b0;
      frame_err_d = (state_q == CMD) || (state_q == DATA);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ss_fall_c) begin
            state_d   = CMD;
            bit_cnt_d = 3'd0;
            rx_d      = 8'h00;
            tx_d      = 8'h00;
            miso_d    = 1'b0;
            busy_d    = 1'b1;
            miso_oe_d = 1'b1;
          end
        end
        CMD, DATA: begin
          if (shift_c) begin
            miso_d = miso_bit_c;
            tx_d   = tx_shift_c;
          end
          if (sample_c) begin
            rx_d      = rx_next_c;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == CMD) begin
                rnw_d   = rx_next_c[7];
                addr_d  = rx_next_c[ADDR_W-1:0];
                tx_d    = rx_next_c[7] ? regs_q[rx_next_c[ADDR_W-1:0]] : 8'h00;
                state_d = DATA;
              end else begin
                reg_we_c    = !rnw_q;
                wr_strobe_d = !rnw_q;
                if (!rnw_q) begin
                  wr_addr_d = addr_q;
                  wr_data_d = rx_next_c;
                end
                miso_d  = 1'b0;
                state_d = HOLD;
              end
            end
          end
        end
        HOLD: miso_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      rnw_q       <= 1'b0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Register file and registered local read port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= 8'h00;
      usr_rdata_q <= 8'h00;
    end else begin
      if (reg_we_c) regs_q[addr_q] <= rx_next_c;
      usr_rdata_q <= regs_q[usr_addr];
    end
  end

  assign MISO      = miso_q;
  assign MISO_oe   = miso_oe_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign usr_rdata = usr_rdata_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: bit-banged SPI master, write/read scoreboards
// and a strobe monitor checking write events against a reference register model.
module tb_spi_slave_regfile;
  localparam int ADDR_W = 3;
  localparam int H      = 8;

  logic clk = 1'b0;
  logic rst, SCK, SS, MOSI, CPOL, CPHA, LSBFE;
  logic [ADDR_W-1:0] usr_addr;
  logic MISO, MISO_oe, wr_strobe, busy, frame_err;
  logic [7:0] usr_rdata, wr_data;
  logic [ADDR_W-1:0] wr_addr;

  int tests = 0;
  int fails = 0;
  int strobe_cnt = 0;
  int ferr_cnt = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] model [8];
  wr_t        mon_e;
  logic       chk_pend = 1'b0;
  wr_t        chk_e;

  spi_slave_regfile #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .SCK(SCK), .SS(SS), .MOSI(MOSI), .MISO(MISO),
    .MISO_oe(MISO_oe), .CPOL(CPOL), .CPHA(CPHA), .LSBFE(LSBFE),
    .usr_addr(usr_addr), .usr_rdata(usr_rdata), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Pops the write scoreboard on every strobe; checks usr_rdata one cycle later.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (chk_pend) begin
        chk_pend = 1'b0;
        if (usr_addr == chk_e.addr) begin
          tests++;
          if (usr_rdata !== chk_e.data) begin
            fails++;
            $display("FAIL usr_rdata_after_strobe: got %h expected %h", usr_rdata, chk_e.data);
          end
        end
      end
      if (wr_strobe === 1'b1) begin
        strobe_cnt++;
        tests++;
        if (exp_wr.size() == 0) begin
          fails++;
          $display("FAIL unexpected_wr_strobe: got addr %0d data %h expected no strobe", wr_addr, wr_data);
        end else begin
          mon_e = exp_wr.pop_front();
          if ({wr_addr, wr_data} !== {mon_e.addr, mon_e.data}) begin
            fails++;
            $display("FAIL wr_event: got addr %0d data %h expected addr %0d data %h",
                     wr_addr, wr_data, mon_e.addr, mon_e.data);
          end
          chk_pend = 1'b1;
          chk_e    = mon_e;
        end
      end
      if (frame_err === 1'b1) ferr_cnt++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_start();
    SCK  = CPOL;
    MOSI = 1'b0;
    SS   = 1'b0;
    wait_clk(H);
  endtask

  task automatic spi_stop();
    wait_clk(H);
    SS = 1'b1;
    wait_clk(3 * H);
  endtask

  task automatic spi_bits(input logic [7:0] txb, input int nbits, output logic [7:0] rxb);
    int idx;
    rxb = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      idx = LSBFE ? i : 7 - i;
      if (!CPHA) begin
        MOSI = txb[idx];
        wait_clk(H);
        SCK = ~CPOL;
        rxb[idx] = MISO;
        wait_clk(H);
        SCK = CPOL;
      end else begin
        SCK  = ~CPOL;
        MOSI = txb[idx];
        wait_clk(H);
        SCK = CPOL;
        rxb[idx] = MISO;
        wait_clk(H);
      end
    end
  endtask

  task automatic frame(input int n, input logic [31:0] txw, output logic [31:0] rxw);
    logic [7:0] rb;
    rxw = '0;
    spi_start();
    for (int k = 0; k < n; k++) begin
      spi_bits(txw[8*k +: 8], 8, rb);
      rxw[8*k +: 8] = rb;
    end
    spi_stop();
  endtask

  task automatic set_mode(input logic pol, input logic pha, input logic lsb);
    CPOL  = pol;
    CPHA  = pha;
    LSBFE = lsb;
    SCK   = pol;
    wait_clk(2 * H);
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    exp_wr.push_back({a, d});
    model[a] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; SS = 1'b1; SCK = 1'b0; MOSI = 1'b0;
    CPOL = 1'b0; CPHA = 1'b0; LSBFE = 1'b0; usr_addr = '0;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({MISO, MISO_oe, busy, wr_strobe, frame_err} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 00000", {MISO, MISO_oe, busy, wr_strobe, frame_err});
    end
    tests++;
    if ({usr_rdata, wr_addr, wr_data} !== '0) begin
      fails++;
      $display("FAIL reset_data: got rdata %h addr %0d data %h expected zeros", usr_rdata, wr_addr, wr_data);
    end
    wait_clk(3);
    rst = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_mode0_write();
    logic [7:0] r0, r1;
    int s0;
    set_mode(1'b0, 1'b0, 1'b0);
    usr_addr = 3'd3;
    s0 = strobe_cnt;
    expect_write(3'd3, 8'h5A);
    spi_start();
    tests++;
    if ({busy, MISO_oe} !== 2'b11) begin
      fails++;
      $display("FAIL busy_oe_in_frame: got %b expected 11", {busy, MISO_oe});
    end
    spi_bits(8'h03, 8, r0);
    spi_bits(8'h5A, 8, r1);
    spi_stop();
    tests++;
    if ({r0, r1} !== 16'h0000) begin
      fails++;
      $display("FAIL write_miso: got %h expected 0000", {r0, r1});
    end
    tests++;
    if (strobe_cnt - s0 !== 1) begin
      fails++;
      $display("FAIL write_strobe_count: got %0d expected 1", strobe_cnt - s0);
    end
    tests++;
    if ({wr_addr, wr_data, usr_rdata} !== {3'd3, 8'h5A, model[3]}) begin
      fails++;
      $display("FAIL write_hold: got addr %0d data %h rdata %h expected 3 5a %h",
               wr_addr, wr_data, usr_rdata, model[3]);
    end
  endtask

  task automatic test_mode0_read();
    logic [31:0] rw;
    int s0;
    logic [7:0] e;
    s0 = strobe_cnt;
    exp_rd.push_back(model[3]);
    frame(2, 32'h0000_0083, rw);
    e = exp_rd.pop_front();
    tests++;
    if (rw[15:0] !== {e, 8'h00}) begin
      fails++;
      $display("FAIL mode0_read: got %h expected %h", rw[15:0], {e, 8'h00});
    end
    tests++;
    if (strobe_cnt - s0 !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL read_no_strobe: got strobes %0d busy %b expected 0 0", strobe_cnt - s0, busy);
    end
  endtask

  task automatic test_modes();
    logic [31:0] rw;
    logic [7:0] d, e;
    for (int m = 0; m < 4; m++) begin
      set_mode(m[1], m[0], 1'b1);
      d = 8'hC3 ^ 8'(m * 8'h11);
      expect_write(3'd5, d);
      frame(2, {16'h0000, d, 8'h05}, rw);
      exp_rd.push_back(model[5]);
      frame(2, 32'h0000_0085, rw);
      e = exp_rd.pop_front();
      tests++;
      if (rw[15:8] !== e) begin
        fails++;
        $display("FAIL mode%0d_lsb_read: got %h expected %h", m, rw[15:8], e);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] r;
    int s0, f0;
    set_mode(1'b0, 1'b0, 1'b0);
    s0 = strobe_cnt;
    f0 = ferr_cnt;
    spi_start();
    spi_bits(8'h01, 8, r);
    spi_bits(8'hFF, 4, r);
    spi_stop();
    usr_addr = 3'd1;
    wait_clk(3);
    tests++;
    if (ferr_cnt - f0 !== 1 || strobe_cnt - s0 !== 0) begin
      fails++;
      $display("FAIL abort_events: got ferr %0d strobes %0d expected 1 0", ferr_cnt - f0, strobe_cnt - s0);
    end
    tests++;
    if ({busy, MISO_oe, MISO, usr_rdata} !== {3'b000, model[1]}) begin
      fails++;
      $display("FAIL abort_state: got %b %h expected 000 %h", {busy, MISO_oe, MISO}, usr_rdata, model[1]);
    end
  endtask

  task automatic test_overlong();
    logic [31:0] rw;
    int s0, f0;
    s0 = strobe_cnt;
    f0 = ferr_cnt;
    expect_write(3'd2, 8'h11);
    frame(4, 32'h3322_1102, rw);
    usr_addr = 3'd2;
    wait_clk(3);
    tests++;
    if (rw !== 32'h0) begin
      fails++;
      $display("FAIL overlong_miso: got %h expected 00000000", rw);
    end
    tests++;
    if (ferr_cnt - f0 !== 0 || strobe_cnt - s0 !== 1) begin
      fails++;
      $display("FAIL overlong_events: got ferr %0d strobes %0d expected 0 1", ferr_cnt - f0, strobe_cnt - s0);
    end
    tests++;
    if (usr_rdata !== model[2]) begin
      fails++;
      $display("FAIL overlong_reg2: got %h expected %h", usr_rdata, model[2]);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] r;
    logic [31:0] rw;
    usr_addr = 3'd2;
    wait_clk(3);
    spi_start();
    spi_bits(8'h07, 3, r);
    rst = 1'b0;
    #1;
    tests++;
    if ({MISO, MISO_oe, busy, wr_strobe, frame_err, usr_rdata, wr_addr, wr_data} !== '0) begin
      fails++;
      $display("FAIL midframe_reset: got %b rdata %h addr %0d data %h expected zeros",
               {MISO, MISO_oe, busy, wr_strobe, frame_err}, usr_rdata, wr_addr, wr_data);
    end
    SS = 1'b1; SCK = CPOL; MOSI = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    wait_clk(4);
    rst = 1'b1;
    wait_clk(4);
    expect_write(3'd7, 8'h99);
    frame(2, 32'h0000_9907, rw);
    usr_addr = 3'd7;
    wait_clk(3);
    tests++;
    if (usr_rdata !== model[7]) begin
      fails++;
      $display("FAIL post_reset_reg7: got %h expected %h", usr_rdata, model[7]);
    end
    usr_addr = 3'd2;
    wait_clk(3);
    tests++;
    if (usr_rdata !== model[2]) begin
      fails++;
      $display("FAIL post_reset_reg2: got %h expected %h", usr_rdata, model[2]);
    end
  endtask

  initial begin
    test_reset();
    test_mode0_write();
    test_mode0_read();
    test_modes();
    test_abort();
    test_overlong();
    test_reset_midframe();
    wait_clk(4);
    tests++;
    if (exp_wr.size() != 0) begin
      fails++;
      $display("FAIL missing_wr_strobe: got %0d pending expected 0", exp_wr.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
